// File: rtl/shifter_operand_encoder_if.sv
// Request/result bundle for the operand-2 encoder.
// The requester drives start/value/ls_mode; the encoder returns status and the encoding.
interface shifter_operand_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        ls_mode;
  logic        busy;
  logic        done;
  logic        found;
  logic        negate;
  logic [11:0] shift_operand;

  modport master (
    output start,
    output value,
    output ls_mode,
    input  busy,
    input  done,
    input  found,
    input  negate,
    input  shift_operand
  );

  modport slave (
    input  start,
    input  value,
    input  ls_mode,
    output busy,
    output done,
    output found,
    output negate,
    output shift_operand
  );
endinterface

// File: rtl/shifter_operand_encoder.sv
// Iterative encoder producing EX-stage operand-2 fields.
// Rotated-immediate mode walks rotate_imm upward one value per cycle and stops at the
// first rotation whose left-rotated constant fits in 8 bits, so the smallest
// rotate_imm always wins. Load/store mode resolves in a single search cycle into a
// magnitude plus negate flag.
module shifter_operand_encoder #(
  parameter int ROT_LIMIT = 15,
  parameter int OFFSET_W  = 12
) (
  input  logic clk,
  input  logic rst,
  shifter_operand_encoder_if.slave bus
);

  localparam logic [3:0] ROT_LAST = 4'(ROT_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t      state_reg;
  logic [31:0] value_reg;
  logic        ls_reg;
  logic [3:0]  rot_reg;

  logic        busy_reg;
  logic        done_reg;
  logic        found_reg;
  logic        negate_reg;
  logic [11:0] operand_reg;

  // Candidate for the current rotation: value rotated left by 2*r.
  // A shift amount of 0 makes the right-shift term 32, which yields zero.
  logic [4:0]  shamt;
  logic [5:0]  shamt_comp;
  logic [31:0] candidate;
  logic        rot_hit;

  assign shamt      = {rot_reg, 1'b0};
  assign shamt_comp = 6'd32 - {1'b0, shamt};
  assign candidate  = (value_reg << shamt) | (value_reg >> shamt_comp);
  assign rot_hit    = (candidate[31:8] == 24'd0);

  // Load/store offset classification. 0x80000000 negates to itself, keeps bit 31
  // set in the magnitude and therefore fails the range test on its own.
  logic [31:0] neg_value;
  logic        pos_fits;
  logic        neg_fits;

  assign neg_value = 32'd0 - value_reg;
  assign pos_fits  = ((value_reg >> OFFSET_W) == 32'd0);
  assign neg_fits  = value_reg[31] && ((neg_value >> OFFSET_W) == 32'd0);

  // Control sequencing and registered outputs; results land on the edge leaving SEARCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      value_reg   <= 32'd0;
      ls_reg      <= 1'b0;
      rot_reg     <= 4'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      found_reg   <= 1'b0;
      negate_reg  <= 1'b0;
      operand_reg <= 12'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            state_reg   <= SEARCH;
            value_reg   <= bus.value;
            ls_reg      <= bus.ls_mode;
            rot_reg     <= 4'd0;
            busy_reg    <= 1'b1;
            found_reg   <= 1'b0;
            negate_reg  <= 1'b0;
            operand_reg <= 12'd0;
          end
        end

        SEARCH: begin
          if (ls_reg) begin
            // Offset encoding needs no iteration.
            state_reg <= DONE;
            done_reg  <= 1'b1;
            if (pos_fits) begin
              found_reg   <= 1'b1;
              negate_reg  <= 1'b0;
              operand_reg <= value_reg[11:0];
            end else if (neg_fits) begin
              found_reg   <= 1'b1;
              negate_reg  <= 1'b1;
              operand_reg <= neg_value[11:0];
            end else begin
              found_reg   <= 1'b0;
              negate_reg  <= 1'b0;
              operand_reg <= 12'd0;
            end
          end else if (rot_hit) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            found_reg   <= 1'b1;
            negate_reg  <= 1'b0;
            operand_reg <= {rot_reg, candidate[7:0]};
          end else if (rot_reg == ROT_LAST) begin
            // Every allowed rotation tried without a fit.
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            found_reg   <= 1'b0;
            negate_reg  <= 1'b0;
            operand_reg <= 12'd0;
          end else begin
            rot_reg <= rot_reg + 4'd1;
          end
        end

        DONE: begin
          // Single-cycle result strobe; start is not accepted here.
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.found         = found_reg;
  assign bus.negate        = negate_reg;
  assign bus.shift_operand = operand_reg;

endmodule

// File: tb/tb_shifter_operand_encoder.sv
// Self-checking bench for shifter_operand_encoder: directed cases plus random
// transactions, compared every cycle against a latency-level behavioural model.
module tb_shifter_operand_encoder;

  localparam int ROT_LIMIT = 15;
  localparam int OFFSET_W  = 12;
  localparam longint OFF_RANGE = longint'(1) << OFFSET_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shifter_operand_encoder_if bus();

  shifter_operand_encoder #(
    .ROT_LIMIT(ROT_LIMIT),
    .OFFSET_W (OFFSET_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rol32(input logic [31:0] x, input int s);
    int k;
    k = s % 32;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    int k;
    k = s % 32;
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  // Reference encoding from the rules: round-trip search over rotations, or
  // signed-range test for offsets. lat = edges from acceptance to done.
  task automatic model_enc(input logic [31:0] v, input bit ls, output bit f, output bit n,
                           output logic [11:0] so, output int lat);
    longint uv;
    longint sv;
    logic [31:0] imm;
    f = 1'b0; n = 1'b0; so = 12'd0;
    if (ls) begin
      lat = 1;
      uv = longint'({32'd0, v});
      sv = longint'($signed(v));
      if (uv < OFF_RANGE) begin
        f = 1'b1; so = v[11:0];
      end else if (sv < 0 && -sv < OFF_RANGE) begin
        f = 1'b1; n = 1'b1; so = 12'(-sv);
      end
    end else begin
      lat = ROT_LIMIT + 1;
      for (int r = 0; r <= ROT_LIMIT; r++) begin
        imm = rol32(v, 2 * r) & 32'h0000_00FF;
        if (ror32(imm, 2 * r) == v) begin
          f = 1'b1; so = {4'(r), imm[7:0]}; lat = r + 1;
          break;
        end
      end
    end
  endtask

  // Model state: expected outputs tracked by edges since acceptance.
  bit          m_active = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [31:0] m_v = 32'd0;
  bit          m_ls = 1'b0;
  bit          r_f, r_n;
  logic [11:0] r_so;
  bit          e_busy = 1'b0, e_done = 1'b0, e_found = 1'b0, e_neg = 1'b0;
  logic [11:0] e_so = 12'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_found = 1'b0; e_neg = 1'b0; e_so = 12'd0;
    end else if (m_active) begin
      m_cnt++;
      if (m_cnt == m_lat) begin
        e_done = 1'b1; e_found = r_f; e_neg = r_n; e_so = r_so;
      end else if (m_cnt == m_lat + 1) begin
        e_done = 1'b0; e_busy = 1'b0; m_active = 1'b0;
      end
    end else if (bus.start) begin
      m_v = bus.value; m_ls = bus.ls_mode;
      model_enc(m_v, m_ls, r_f, r_n, r_so, m_lat);
      m_active = 1'b1; m_cnt = 0;
      e_busy = 1'b1; e_done = 1'b0; e_found = 1'b0; e_neg = 1'b0; e_so = 12'd0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("done", 32'(bus.done), 32'(e_done));
      check("found", 32'(bus.found), 32'(e_found));
      check("negate", 32'(bus.negate), 32'(e_neg));
      check("shift_operand", 32'(bus.shift_operand), 32'(e_so));
      if (e_done)
        $display("txn value=%08h ls_mode=%0d found=%0d negate=%0d shift_operand=%03h latency=%0d",
                 m_v, m_ls, bus.found, bus.negate, bus.shift_operand, m_lat);
    end
  end

  // Called at a negedge; leaves start low after edge 0.
  task automatic pulse_start(input logic [31:0] v, input bit ls);
    bus.start = 1'b1; bus.value = v; bus.ls_mode = ls;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int pulse_at, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      bus.start = (n == pulse_at);
      if (n == pulse_at) begin
        bus.value = 32'h0000_00FF; bus.ls_mode = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic run_txn(input logic [31:0] v, input bit ls, input int pulse_at, input bit poke_done,
                         input bit lit, input int exp_lat, input bit exp_f, input bit exp_n,
                         input logic [11:0] exp_so);
    int lat;
    pulse_start(v, ls);
    wait_done(pulse_at, lat);
    if (lit) begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("lit_found", 32'(bus.found), 32'(exp_f));
      check("lit_negate", 32'(bus.negate), 32'(exp_n));
      check("lit_operand", 32'(bus.shift_operand), 32'(exp_so));
    end
    // Leave the DONE cycle; optionally try a start there, which must be ignored.
    bus.start = poke_done; bus.value = $urandom; bus.ls_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit f, n;
    logic [11:0] so;
    int lat, sel, done_seen;
    logic [31:0] v;
    logic [31:0] edge_vals [5];

    bus.start = 1'b0; bus.value = 32'd0; bus.ls_mode = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_operand", 32'(bus.shift_operand), 32'd0);

    // Pin the model to hand-computed encodings.
    model_enc(32'hFF00_0000, 1'b0, f, n, so, lat);
    check("model_ff000000_so", 32'(so), 32'h4FF); check("model_ff000000_lat", 32'(lat), 32'd5);
    model_enc(32'hF000_000F, 1'b0, f, n, so, lat);
    check("model_f000000f_so", 32'(so), 32'h2FF); check("model_f000000f_lat", 32'(lat), 32'd3);
    model_enc(32'h0000_0102, 1'b0, f, n, so, lat);
    check("model_102_found", 32'(f), 32'd0); check("model_102_lat", 32'(lat), 32'd16);
    model_enc(32'hFFFF_FFFC, 1'b1, f, n, so, lat);
    check("model_neg4_so", 32'(so), 32'h004); check("model_neg4_neg", 32'(n), 32'd1);
    model_enc(32'h8000_0000, 1'b1, f, n, so, lat);
    check("model_80000000_found", 32'(f), 32'd0);
    model_enc(32'h0000_03FC, 1'b0, f, n, so, lat);
    check("model_3fc_so", 32'(so), 32'hFFF);

    // Directed cases with literal expectations.
    run_txn(32'h0000_0000, 1'b0, 0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 12'h000);
    run_txn(32'h0000_00FF, 1'b0, 0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 12'h0FF);
    run_txn(32'hFF00_0000, 1'b0, 0, 1'b1, 1'b1, 5, 1'b1, 1'b0, 12'h4FF);
    run_txn(32'hF000_000F, 1'b0, 0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 12'h2FF);
    run_txn(32'h0000_0102, 1'b0, 5, 1'b0, 1'b1, 16, 1'b0, 1'b0, 12'h000);
    run_txn(32'h0000_0FFF, 1'b1, 0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 12'hFFF);
    run_txn(32'hFFFF_FFFC, 1'b1, 0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 12'h004);
    run_txn(32'h0000_1000, 1'b1, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 12'h000);
    run_txn(32'h8000_0000, 1'b1, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 12'h000);

    // Reset in the middle of a search aborts it without a done pulse.
    pulse_start(32'h0000_0102, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_found", 32'(bus.found), 32'd0);
    run_txn(32'h0000_03FC, 1'b0, 0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 12'hFFF);

    // Randomized transactions checked by the per-cycle model.
    edge_vals[0] = 32'h8000_0000; edge_vals[1] = 32'hFFFF_F000; edge_vals[2] = 32'hFFFF_F001;
    edge_vals[3] = 32'h0000_1000; edge_vals[4] = 32'h0000_0FFF;
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: run_txn(ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15)), 1'b0, 0,
                   ($urandom_range(0, 3) == 0), 1'b0, 0, 1'b0, 1'b0, 12'h000);
        1: run_txn($urandom, 1'b0, 0, ($urandom_range(0, 3) == 0), 1'b0, 0, 1'b0, 1'b0, 12'h000);
        2: run_txn(32'($urandom_range(0, 8191)), 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 12'h000);
        3: begin
          v = 32'd0 - 32'($urandom_range(0, 8191));
          run_txn(v, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 12'h000);
        end
        default: begin
          v = ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
          run_txn(v, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 12'h000);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
